qf_rhw_wr_arb: RTL
==================

// Module: qf_rhw_wr_arb
// PURPOSE
//  Round-robin arbiter/sequencer sharing hardware-write access to a bank of qf_rhw status registers.
//  Up to PAR_NUM_REQ FCB agents each request a write of (addr, data); one write is issued per grant.
//  The write is a one-hot hw_wr_en strobe plus a shared hw_wrdata bus that fans out to every register.
//  Also counts contention cycles for debug.
// PARAMETERS
//  PAR_NUM_REQ    4   number of requesters (>=2)
//  PAR_NUM_REGS   6   number of target registers (1..2**PAR_ADDR_WIDTH)
//  PAR_ADDR_WIDTH 3   register address width
//  PAR_BIT_WIDTH  10  register data width
//  PAR_CNT_WIDTH  8   contention counter width
// PORTS
//  sys_clk     in   1                          clock
//  sys_rst_n   in   1                          asynchronous active-low reset
//  arb_en      in   1                          1 = new grants allowed
//  req_i       in   PAR_NUM_REQ                per-requester write request, level
//  req_addr_i  in   PAR_NUM_REQ*PAR_ADDR_WIDTH packed addresses, requester k at [k*A +: A]
//  req_data_i  in   PAR_NUM_REQ*PAR_BIT_WIDTH  packed data, requester k at [k*W +: W]
//  ack_o       in/o out PAR_NUM_REQ            one-cycle completion pulse per requester
//  addr_err_o  out  1                          one-cycle pulse, granted addr >= PAR_NUM_REGS
//  hw_wr_en_o  out  PAR_NUM_REGS               one-hot write strobe to register bank
//  hw_wrdata_o out  PAR_BIT_WIDTH              write data to register bank
//  busy_o      out  1                          1 while in WRITE state
//  coll_cnt_o  out  PAR_CNT_WIDTH              saturating contention counter
//  cnt_clr_i   in   1                          synchronous clear of coll_cnt_o
// BEHAVIOUR
//  Clock/reset: clock sys_clk; reset sys_rst_n, asynchronous, active-low.
//  Reset values:
//   - All outputs registered; every output resets to 0.
//   - State = IDLE; round-robin pointer = 0 (requester 0 highest priority).
//  FSM states: IDLE, WRITE.
//  IDLE:
//   - If arb_en=1 and any req_i set, grant the first set req at or after the pointer (cyclic order).
//   - Latch that requester's addr and data; go to WRITE.
//   - Otherwise stay in IDLE.
//  WRITE (exactly one cycle):
//   - If latched addr < PAR_NUM_REGS: hw_wr_en_o[addr]=1 and hw_wrdata_o=latched data.
//   - Else hw_wr_en_o=0 and addr_err_o=1.
//   - ack_o[g]=1 in both cases; busy_o=1.
//   - On exit: pointer = (g+1) mod PAR_NUM_REQ; always return to IDLE.
//  Timing:
//   - req sampled at edge t -> strobe/ack high during cycle t+1 -> low at t+2.
//   - Throughput: max one write per 2 cycles; worst-case wait for any requester is 2*PAR_NUM_REQ cycles.
//  Requester protocol:
//   - Hold req, addr and data stable until ack.
//   - Drop req in the cycle after ack, or keep req high to queue another write.
//   - A req still high in the ack cycle is not granted in that cycle (state = WRITE) and is eligible from the next IDLE.
//   - req_i/addr/data changes while in WRITE are ignored; the latched values are used.
//  hw_wrdata_o holds its last value when no strobe is active; only hw_wr_en_o qualifies it.
//  arb_en:
//   - arb_en=0 blocks new grants only.
//   - A WRITE already in progress completes and acks.
//  Contention counter:
//   - Increments by 1 on every grant cycle with >=2 req_i set.
//   - Saturates at all-ones, no wrap.
//   - cnt_clr_i=1 forces 0; clear beats increment when both occur in the same cycle.
//  Reset mid-WRITE:
//   - Strobe and ack drop asynchronously; the write is lost, with no ack.
//   - Pointer and counter return to 0.
// TESTING
//  1. Single req: req_i=0001, addr=2, data=0x155 -> hw_wr_en_o=000100, hw_wrdata_o=0x155, ack_o=0001 one cycle after grant.
//  2. All 4 reqs held: grants in order 0,1,2,3,0, every 2 cycles; coll_cnt_o increments on each grant while >=2 reqs are pending.
//  3. Addr=7 with PAR_NUM_REGS=6 -> hw_wr_en_o=0, addr_err_o=1 and ack still pulsed.
//  4. arb_en=0 while req_i=0010 -> no grant; raise arb_en -> ack in 2 cycles. Drop arb_en during WRITE -> that write still completes.
//  5. Counter: force 300 contention grants (W=8) -> coll_cnt_o=255; cnt_clr_i on an increment cycle -> 0.
//  6. Assert reset during WRITE -> hw_wr_en_o and ack_o go to 0 at once; after release, requester 0 wins a 4-way tie.

Source files
------------

// File: rtl/qf_rhw_wr_arb.sv
// -----------------------------------------------------------------------------
// qf_rhw_wr_arb
//
// Round-robin arbiter and write sequencer for the hardware-write side of a
// bank of qf_rhw status registers. Each FCB agent raises a level request with
// a register address and a data word. The arbiter grants one agent at a time
// and then spends exactly one cycle issuing the write:
//   - a one-hot strobe on hw_wr_en_o that selects the target register
//   - the data on hw_wrdata_o, which fans out to every register
// The write completes with a one-cycle ack to the granted agent. An address
// beyond the populated bank is not written. It is reported on addr_err_o and
// is still acked, so the agent never stalls.
// A saturating debug counter records grant cycles that had competition.
//
// Ports
//   sys_clk      in   clock
//   sys_rst_n    in   asynchronous active-low reset
//   arb_en       in   1 = new grants allowed; a write already issued completes
//   req_i        in   [PAR_NUM_REQ]  per-requester write request (level)
//   req_addr_i   in   [PAR_NUM_REQ*PAR_ADDR_WIDTH]  requester k at [k*A +: A]
//   req_data_i   in   [PAR_NUM_REQ*PAR_BIT_WIDTH]   requester k at [k*W +: W]
//   ack_o        out  [PAR_NUM_REQ]  one-cycle completion pulse
//   addr_err_o   out  one-cycle pulse, granted address >= PAR_NUM_REGS
//   hw_wr_en_o   out  [PAR_NUM_REGS] one-hot write strobe to the register bank
//   hw_wrdata_o  out  [PAR_BIT_WIDTH] write data; valid only under a strobe
//   busy_o       out  1 while a write cycle is in progress
//   coll_cnt_o   out  [PAR_CNT_WIDTH] saturating contention counter
//   cnt_clr_i    in   synchronous clear of coll_cnt_o (wins over increment)
//
// Timing: a request sampled at edge t produces strobe/ack/busy during the
// cycle after edge t. These signals drop again at edge t+1. Every output is
// driven directly by a flop.
// -----------------------------------------------------------------------------
module qf_rhw_wr_arb #(
   parameter int PAR_NUM_REQ    = 4,
   parameter int PAR_NUM_REGS   = 6,
   parameter int PAR_ADDR_WIDTH = 3,
   parameter int PAR_BIT_WIDTH  = 10,
   parameter int PAR_CNT_WIDTH  = 8
) (
   input  logic                                   sys_clk,
   input  logic                                   sys_rst_n,
   input  logic                                   arb_en,
   input  logic [PAR_NUM_REQ-1:0]                 req_i,
   input  logic [PAR_NUM_REQ*PAR_ADDR_WIDTH-1:0]  req_addr_i,
   input  logic [PAR_NUM_REQ*PAR_BIT_WIDTH-1:0]   req_data_i,
   output logic [PAR_NUM_REQ-1:0]                 ack_o,
   output logic                                   addr_err_o,
   output logic [PAR_NUM_REGS-1:0]                hw_wr_en_o,
   output logic [PAR_BIT_WIDTH-1:0]               hw_wrdata_o,
   output logic                                   busy_o,
   output logic [PAR_CNT_WIDTH-1:0]               coll_cnt_o,
   input  logic                                   cnt_clr_i
);

   // Width of a requester index / round-robin pointer.
   localparam int PTR_W = (PAR_NUM_REQ > 1) ? $clog2(PAR_NUM_REQ) : 1;

   // One extra bit, so that a bank of exactly 2**PAR_ADDR_WIDTH registers
   // makes every address valid.
   localparam logic [PAR_ADDR_WIDTH:0] REG_LIMIT = PAR_NUM_REGS[PAR_ADDR_WIDTH:0];

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_WRITE = 1'b1
   } state_t;

   state_t                     state_q;
   state_t                     state_d;

   // Round-robin pointer: the requester with highest priority at the next grant.
   logic [PTR_W-1:0]           ptr_q;

   // Requester that owns the write in progress. The pointer advances past
   // this requester when the write cycle ends.
   logic [PTR_W-1:0]           gnt_q;

   // Arbitration result for the current cycle.
   logic                       gnt_vld;
   logic [PTR_W-1:0]           gnt_idx;
   logic [PAR_ADDR_WIDTH-1:0]  sel_addr;
   logic [PAR_BIT_WIDTH-1:0]   sel_data;
   logic                       grant_fire;
   logic                       addr_ok;
   logic                       multi_req;

   // Next values of the registered outputs.
   logic [PAR_NUM_REQ-1:0]     ack_d;
   logic                       err_d;
   logic [PAR_NUM_REGS-1:0]    wr_en_d;
   logic [PAR_BIT_WIDTH-1:0]   wrdata_d;
   logic                       busy_d;
   logic [PAR_CNT_WIDTH-1:0]   cnt_d;

   // ------------------------------------------------------------------------
   // Cyclic index helper: (base + off) mod PAR_NUM_REQ. The caller keeps
   // base < PAR_NUM_REQ and off < PAR_NUM_REQ, so one conditional subtract
   // replaces a general modulo.
   // ------------------------------------------------------------------------
   function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] base,
                                                 input int               off);
      int sum;
      sum = int'(base) + off;
      if (sum >= PAR_NUM_REQ) begin
         sum = sum - PAR_NUM_REQ;
      end
      return PTR_W'(sum);
   endfunction

   // ------------------------------------------------------------------------
   // Round-robin search: scan from the pointer and take the first requester
   // that is set.
   // ------------------------------------------------------------------------
   always_comb begin
      // NOTE: every variable gets a default before any conditional assignment;
      // a path that leaves one unassigned would infer a latch.
      gnt_vld = 1'b0;
      gnt_idx = '0;
      for (int i = 0; i < PAR_NUM_REQ; i++) begin
         if (!gnt_vld && req_i[wrap_idx(ptr_q, i)]) begin
            gnt_vld = 1'b1;
            gnt_idx = wrap_idx(ptr_q, i);
         end
      end
   end

   // Route the winning requester's address and data.
   always_comb begin
      sel_addr = '0;
      sel_data = '0;
      for (int k = 0; k < PAR_NUM_REQ; k++) begin
         if (gnt_idx == PTR_W'(k)) begin
            sel_addr = req_addr_i[k*PAR_ADDR_WIDTH +: PAR_ADDR_WIDTH];
            sel_data = req_data_i[k*PAR_BIT_WIDTH +: PAR_BIT_WIDTH];
         end
      end
   end

   // A grant is made only from IDLE. Requests seen during WRITE wait for the
   // next IDLE cycle, so the fastest rate is one write every two cycles.
   assign grant_fire = (state_q == ST_IDLE) && arb_en && gnt_vld;
   assign addr_ok    = {1'b0, sel_addr} < REG_LIMIT;
   assign multi_req  = $countones(req_i) > 1;

   // ------------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------------
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         // NOTE: sequential state uses non-blocking assignments only, so every
         // flop samples values from before the edge, whatever the block order.
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ------------------------------------------------------------------------
   // FSM: next-state logic. WRITE lasts exactly one cycle and always returns
   // to IDLE. arb_en blocks only the IDLE -> WRITE transition.
   // ------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (grant_fire) begin
               state_d = ST_WRITE;
            end
         end
         ST_WRITE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // FSM: output logic. This block computes the values the output flops load
   // on the grant edge, so strobe, ack and busy are high for the whole WRITE
   // cycle. hw_wrdata_o keeps its old value unless a strobe accompanies it.
   // ------------------------------------------------------------------------
   always_comb begin
      ack_d    = '0;
      err_d    = 1'b0;
      wr_en_d  = '0;
      wrdata_d = hw_wrdata_o;
      busy_d   = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (grant_fire) begin
               busy_d = 1'b1;
               for (int k = 0; k < PAR_NUM_REQ; k++) begin
                  ack_d[k] = (gnt_idx == PTR_W'(k));
               end
               if (addr_ok) begin
                  for (int r = 0; r < PAR_NUM_REGS; r++) begin
                     wr_en_d[r] = (sel_addr == PAR_ADDR_WIDTH'(r));
                  end
                  wrdata_d = sel_data;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         ST_WRITE: begin
            // Every pulse drops here; a new grant is evaluated from IDLE.
         end
         default: begin
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Output flops. An asynchronous reset clears them at once, so a write in
   // flight is abandoned with no strobe and no ack.
   // ------------------------------------------------------------------------
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         ack_o       <= '0;
         addr_err_o  <= 1'b0;
         hw_wr_en_o  <= '0;
         hw_wrdata_o <= '0;
         busy_o      <= 1'b0;
      end else begin
         ack_o       <= ack_d;
         addr_err_o  <= err_d;
         hw_wr_en_o  <= wr_en_d;
         hw_wrdata_o <= wrdata_d;
         busy_o      <= busy_d;
      end
   end

   // ------------------------------------------------------------------------
   // Grant ownership and round-robin pointer. The pointer moves past the
   // granted requester when WRITE ends. Until then the pointer used by the
   // arbiter is unchanged, but no grant can happen in WRITE anyway.
   // ------------------------------------------------------------------------
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         gnt_q <= '0;
         ptr_q <= '0;
      end else begin
         if (grant_fire) begin
            gnt_q <= gnt_idx;
         end
         if (state_q == ST_WRITE) begin
            ptr_q <= wrap_idx(gnt_q, 1);
         end
      end
   end

   // ------------------------------------------------------------------------
   // Contention counter: counts grant cycles with two or more requests
   // present. It saturates at all-ones, and a clear wins over an increment in
   // the same cycle.
   // ------------------------------------------------------------------------
   always_comb begin
      cnt_d = coll_cnt_o;
      if (cnt_clr_i) begin
         cnt_d = '0;
      end else if (grant_fire && multi_req && (coll_cnt_o != '1)) begin
         cnt_d = coll_cnt_o + PAR_CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         coll_cnt_o <= '0;
      end else begin
         coll_cnt_o <= cnt_d;
      end
   end

endmodule
